// File: rtl/pic_icsp_tx.sv
// ICSP serial engine: shifts a 6-bit command out on PGC/PGD, optionally
// followed by a 16-slot data frame that is either driven or read back.
module pic_icsp_tx #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned GAP_CYC = 8
) (
  input  logic        clk_x,
  input  logic        rst_x,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_code,
  input  logic        cmd_has_data,
  input  logic        cmd_is_read,
  input  logic [13:0] cmd_data,
  output logic        pgc,
  output logic        pgd_out,
  output logic        pgd_oe,
  input  logic        pgd_in,
  output logic        busy,
  output logic        done,
  output logic [13:0] rd_data,
  output logic        rd_valid
);

  localparam int unsigned SLOT_CYC = 2 * CLK_DIV;
  localparam int unsigned PW       = $clog2(SLOT_CYC);
  localparam int unsigned GW       = $clog2(GAP_CYC + 1);

  localparam logic [PW-1:0] PH_LAST  = PW'(SLOT_CYC - 1);
  localparam logic [PW-1:0] PH_HIGH  = PW'(CLK_DIV);
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_GAP,
    S_DATA,
    S_FIN
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [3:0]    slot_q, slot_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [5:0]    code_q, code_d;
  logic          has_data_q, has_data_d;
  logic          is_read_q, is_read_d;
  logic [13:0]   data_q, data_d;
  logic [13:0]   shift_q, shift_d;
  logic [13:0]   rd_data_q, rd_data_d;

  logic          slot_end;
  logic [15:0]   frame;

  assign slot_end = (phase_q == PH_LAST);
  // Data frame as sent on the wire: start 0, payload LSB first, stop 0.
  assign frame    = {1'b0, data_q, 1'b0};
  assign rd_data  = rd_data_q;

  always_ff @(posedge clk_x or posedge rst_x) begin
    if (rst_x) begin
      state_q    <= S_IDLE;
      phase_q    <= '0;
      slot_q     <= '0;
      gap_q      <= '0;
      code_q     <= '0;
      has_data_q <= 1'b0;
      is_read_q  <= 1'b0;
      data_q     <= '0;
      shift_q    <= '0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      slot_q     <= slot_d;
      gap_q      <= gap_d;
      code_q     <= code_d;
      has_data_q <= has_data_d;
      is_read_q  <= is_read_d;
      data_q     <= data_d;
      shift_q    <= shift_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    slot_d     = slot_q;
    gap_d      = gap_q;
    code_d     = code_q;
    has_data_d = has_data_q;
    is_read_d  = is_read_q;
    data_d     = data_q;
    shift_d    = shift_q;
    rd_data_d  = rd_data_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          code_d     = cmd_code;
          has_data_d = cmd_has_data;
          is_read_d  = cmd_is_read && cmd_has_data;
          data_d     = cmd_data;
          phase_d    = '0;
          slot_d     = '0;
          gap_d      = '0;
          state_d    = S_CMD;
        end
      end

      S_CMD: begin
        phase_d = phase_q + PW'(1);
        if (slot_end) begin
          phase_d = '0;
          if (slot_q == 4'd5) begin
            slot_d  = '0;
            gap_d   = '0;
            state_d = has_data_q ? S_GAP : S_FIN;
          end else begin
            slot_d = slot_q + 4'd1;
          end
        end
      end

      S_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GAP_LAST) begin
          state_d = S_DATA;
        end
      end

      S_DATA: begin
        phase_d = phase_q + PW'(1);
        // Sample in the last high cycle, just before the falling edge.
        if (is_read_q && slot_end && (slot_q >= 4'd1) && (slot_q <= 4'd14)) begin
          shift_d = {pgd_in, shift_q[13:1]};
        end
        if (slot_end) begin
          phase_d = '0;
          if (slot_q == 4'd15) begin
            slot_d  = '0;
            state_d = S_FIN;
            if (is_read_q) begin
              rd_data_d = shift_q;
            end
          end else begin
            slot_d = slot_q + 4'd1;
          end
        end
      end

      S_FIN: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    pgc       = 1'b0;
    pgd_out   = 1'b0;
    pgd_oe    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    rd_valid  = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
      end

      S_CMD: begin
        busy    = 1'b1;
        pgd_oe  = 1'b1;
        pgc     = (phase_q >= PH_HIGH);
        pgd_out = code_q[slot_q[2:0]];
      end

      S_GAP: begin
        busy   = 1'b1;
        pgd_oe = !is_read_q;
      end

      S_DATA: begin
        busy = 1'b1;
        pgc  = (phase_q >= PH_HIGH);
        if (!is_read_q) begin
          pgd_oe  = 1'b1;
          pgd_out = frame[slot_q];
        end
      end

      S_FIN: begin
        busy     = 1'b1;
        done     = 1'b1;
        rd_valid = is_read_q;
      end

      default: begin
        cmd_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_pic_icsp_tx.sv
// Bench for pic_icsp_tx: two instances (CLK_DIV/GAP_CYC 4/8 and 1/1) checked
// every cycle against a timeline model, plus directed literal expectations.
`timescale 1ns/1ps
module tb_pic_icsp_tx;

  logic clk_x = 1'b0;
  logic rst_x = 1'b1;

  logic [1:0]        cmd_valid_v = '0;
  logic [1:0]        cmd_has_v   = '0;
  logic [1:0]        cmd_rd_v    = '0;
  logic [1:0]        pgd_in_v    = '0;
  logic [1:0][5:0]   cmd_code_v  = '0;
  logic [1:0][13:0]  cmd_data_v  = '0;
  logic [1:0][13:0]  dev_word    = '0;

  logic [1:0]        cmd_ready_v, pgc_v, pgd_out_v, pgd_oe_v, busy_v, done_v, rd_valid_v;
  logic [1:0][13:0]  rd_data_v;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk_x = ~clk_x;
  always @(posedge clk_x) cyc <= cyc + 1;

  pic_icsp_tx #(.CLK_DIV(4), .GAP_CYC(8)) u_dut0 (
    .clk_x(clk_x), .rst_x(rst_x),
    .cmd_valid(cmd_valid_v[0]), .cmd_ready(cmd_ready_v[0]),
    .cmd_code(cmd_code_v[0]), .cmd_has_data(cmd_has_v[0]),
    .cmd_is_read(cmd_rd_v[0]), .cmd_data(cmd_data_v[0]),
    .pgc(pgc_v[0]), .pgd_out(pgd_out_v[0]), .pgd_oe(pgd_oe_v[0]),
    .pgd_in(pgd_in_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .rd_data(rd_data_v[0]), .rd_valid(rd_valid_v[0])
  );

  pic_icsp_tx #(.CLK_DIV(1), .GAP_CYC(1)) u_dut1 (
    .clk_x(clk_x), .rst_x(rst_x),
    .cmd_valid(cmd_valid_v[1]), .cmd_ready(cmd_ready_v[1]),
    .cmd_code(cmd_code_v[1]), .cmd_has_data(cmd_has_v[1]),
    .cmd_is_read(cmd_rd_v[1]), .cmd_data(cmd_data_v[1]),
    .pgc(pgc_v[1]), .pgd_out(pgd_out_v[1]), .pgd_oe(pgd_oe_v[1]),
    .pgd_in(pgd_in_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .rd_data(rd_data_v[1]), .rd_valid(rd_valid_v[1])
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected {pgc, pgd_out, pgd_oe, busy, done, rd_valid} at cycle t after accept.
  function automatic logic [5:0] exp_at(input int cd, input int gp, input int t,
                                        input logic [5:0] code, input logic hd,
                                        input logic rd, input logic [13:0] d);
    int cl, len, u, s, ph;
    logic [15:0] fr;
    cl  = 12 * cd;
    len = cl + 1 + (hd ? gp + 32 * cd : 0);
    fr  = {1'b0, d, 1'b0};
    if (t < cl) begin
      s  = t / (2 * cd);
      ph = t % (2 * cd);
      return {ph >= cd, code[s], 4'b1100};
    end
    if (t == len - 1) return {4'b0001, 1'b1, rd};
    if (t < cl + gp) return {2'b00, ~rd, 3'b100};
    u  = t - cl - gp;
    s  = u / (2 * cd);
    ph = u % (2 * cd);
    return {ph >= cd, rd ? 1'b0 : fr[s], ~rd, 3'b100};
  endfunction

  bit          act_m  [2] = '{default: 1'b0};
  int          t_m    [2] = '{default: 0};
  logic [5:0]  pc_m   [2] = '{default: '0};
  logic        ph_m   [2] = '{default: 1'b0};
  logic        pr_m   [2] = '{default: 1'b0};
  logic [13:0] pd_m   [2] = '{default: '0};
  logic [13:0] dm_m   [2] = '{default: '0};
  logic [13:0] rdm    [2] = '{default: '0};
  int          fn     [2] = '{default: 0};
  logic [31:0] fb     [2] = '{default: '0};
  logic        prev_c [2] = '{default: 1'b0};
  logic        prev_d [2] = '{default: 1'b0};

  // Single compare process: model timeline, device read-back driver, pgc-fall sampler.
  always @(negedge clk_x) begin
    for (int k = 0; k < 2; k++) begin
      int cd, gp, len, u, s;
      logic [5:0] e;
      cd  = (k == 0) ? 4 : 1;
      gp  = (k == 0) ? 8 : 1;
      len = 12 * cd + 1 + (ph_m[k] ? gp + 32 * cd : 0);
      if (rst_x) begin
        act_m[k] = 1'b0;
        rdm[k]   = '0;
      end
      e = act_m[k] ? exp_at(cd, gp, t_m[k], pc_m[k], ph_m[k], pr_m[k], pd_m[k]) : 6'b0;
      if (act_m[k] && t_m[k] == len - 1 && pr_m[k]) rdm[k] = dm_m[k];
      check($sformatf("dut%0d_outs_t%0d", k, t_m[k]),
            32'({pgc_v[k], pgd_out_v[k], pgd_oe_v[k], busy_v[k], done_v[k], rd_valid_v[k]}),
            32'(e));
      check($sformatf("dut%0d_rd_data", k), 32'(rd_data_v[k]), 32'(rdm[k]));
      check($sformatf("dut%0d_cmd_ready", k), 32'(cmd_ready_v[k]), 32'(!act_m[k]));

      pgd_in_v[k] = 1'($urandom_range(0, 1));
      if (act_m[k] && pr_m[k]) begin
        pgd_in_v[k] = 1'b1;
        u = t_m[k] - 12 * cd - gp;
        if (u >= 0) begin
          s = u / (2 * cd);
          if (s >= 1 && s <= 14) pgd_in_v[k] = dm_m[k][s-1];
        end
      end

      if (prev_c[k] && !pgc_v[k] && fn[k] < 32) begin
        fb[k][fn[k]] = prev_d[k];
        fn[k]++;
      end
      prev_c[k] = pgc_v[k];
      prev_d[k] = pgd_out_v[k];

      if (act_m[k]) begin
        t_m[k]++;
        if (t_m[k] == len) act_m[k] = 1'b0;
      end else if (!rst_x && cmd_valid_v[k]) begin
        act_m[k] = 1'b1;
        t_m[k]   = 0;
        pc_m[k]  = cmd_code_v[k];
        ph_m[k]  = cmd_has_v[k];
        pr_m[k]  = cmd_has_v[k] & cmd_rd_v[k];
        pd_m[k]  = cmd_data_v[k];
        dm_m[k]  = dev_word[k];
        fn[k]    = 0;
        fb[k]    = '0;
      end
    end
  end

  task automatic xfer(input int k, input logic [5:0] c, input logic hd, input logic rd,
                      input logic [13:0] d, input logic [13:0] dev, output int lat);
    int acc;
    @(posedge clk_x); #1;
    cmd_valid_v[k] = 1'b1;
    cmd_code_v[k]  = c;
    cmd_has_v[k]   = hd;
    cmd_rd_v[k]    = rd;
    cmd_data_v[k]  = d;
    dev_word[k]    = dev;
    @(posedge clk_x); #1;
    acc            = cyc;
    cmd_valid_v[k] = 1'b0;
    cmd_code_v[k]  = 6'($urandom);
    cmd_has_v[k]   = 1'($urandom);
    cmd_rd_v[k]    = 1'($urandom);
    cmd_data_v[k]  = 14'($urandom);
    lat = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_x);
      if (done_v[k]) begin
        lat = cyc + 1 - acc;
        break;
      end
    end
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat, acc1;
    bit seen;

    #1;
    check("reset_outs", 32'({pgc_v[0], pgd_out_v[0], pgd_oe_v[0], busy_v[0], done_v[0], rd_valid_v[0]}), 32'h0);
    check("reset_ready", 32'(cmd_ready_v[0]), 32'h1);
    check("reset_rd_data", 32'(rd_data_v[0]), 32'h0);
    repeat (3) @(posedge clk_x);
    #1 rst_x = 1'b0;

    // Command only, 0x06
    xfer(0, 6'h06, 1'b0, 1'b0, 14'h0, 14'h0, lat);
    check("cmd06_latency", 32'(lat), 32'd49);
    check("cmd06_falls", 32'(fn[0]), 32'd6);
    check("cmd06_bits", fb[0], 32'h06);

    // Write 0x02 / 0x3FFF
    xfer(0, 6'h02, 1'b1, 1'b0, 14'h3FFF, 14'h0, lat);
    check("wr_latency", 32'(lat), 32'd185);
    check("wr_falls", 32'(fn[0]), 32'd22);
    check("wr_bits", fb[0], 32'({1'b0, 14'h3FFF, 1'b0, 6'h02}));
    check("wr_rd_valid", 32'(rd_valid_v[0]), 32'h0);

    // Read 0x04, device returns 0x1A5C
    xfer(0, 6'h04, 1'b1, 1'b1, 14'h0, 14'h1A5C, lat);
    check("rd_latency", 32'(lat), 32'd185);
    check("rd_done_data", 32'(rd_data_v[0]), 32'h1A5C);
    check("rd_done_valid", 32'(rd_valid_v[0]), 32'h1);
    repeat (100) @(posedge clk_x);
    #1 check("rd_hold_data", 32'(rd_data_v[0]), 32'h1A5C);

    // Back-to-back with cmd_valid noise mid-transfer
    @(posedge clk_x); #1;
    cmd_valid_v[0] = 1'b1; cmd_code_v[0] = 6'h06; cmd_has_v[0] = 1'b0; cmd_rd_v[0] = 1'b0;
    @(posedge clk_x); #1;
    acc1 = cyc;
    for (int i = 0; i < 40; i++) begin
      cmd_valid_v[0] = 1'($urandom);
      cmd_code_v[0]  = 6'($urandom);
      cmd_has_v[0]   = 1'($urandom);
      cmd_data_v[0]  = 14'($urandom);
      @(posedge clk_x); #1;
    end
    cmd_valid_v[0] = 1'b1; cmd_code_v[0] = 6'h08; cmd_has_v[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_x);
      if (done_v[0]) seen = 1'b1;
    end
    #1;
    check("b2b_first_latency", 32'(cyc + 1 - acc1), 32'd49);
    check("b2b_first_bits", fb[0], 32'h06);
    @(posedge clk_x); #1;
    check("b2b_idle_ready", 32'(cmd_ready_v[0]), 32'h1);
    @(posedge clk_x); #1;
    check("b2b_second_accepted", 32'(busy_v[0]), 32'h1);
    acc1 = cyc;
    cmd_valid_v[0] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk_x);
      if (done_v[0]) seen = 1'b1;
    end
    #1;
    check("b2b_second_latency", 32'(cyc + 1 - acc1), 32'd49);
    check("b2b_second_bits", fb[0], 32'h08);

    // Reset in data slot 7 of a write
    @(posedge clk_x); #1;
    cmd_valid_v[0] = 1'b1; cmd_code_v[0] = 6'h02; cmd_has_v[0] = 1'b1; cmd_rd_v[0] = 1'b0;
    cmd_data_v[0] = 14'h2AAA;
    @(posedge clk_x); #1;
    cmd_valid_v[0] = 1'b0;
    repeat (117) @(posedge clk_x);
    #2;
    check("rst_pre_pgc", 32'(pgc_v[0]), 32'h1);
    rst_x = 1'b1;
    #1;
    check("rst_pgc", 32'(pgc_v[0]), 32'h0);
    check("rst_pgd_oe", 32'(pgd_oe_v[0]), 32'h0);
    check("rst_busy", 32'(busy_v[0]), 32'h0);
    repeat (2) @(posedge clk_x);
    #1 rst_x = 1'b0;
    xfer(0, 6'h06, 1'b0, 1'b0, 14'h0, 14'h0, lat);
    check("post_rst_latency", 32'(lat), 32'd49);
    check("post_rst_bits", fb[0], 32'h06);

    // Minimal timing instance: read
    xfer(1, 6'h04, 1'b1, 1'b1, 14'h0, 14'h2C93, lat);
    check("fast_rd_latency", 32'(lat), 32'd46);
    check("fast_rd_data", 32'(rd_data_v[1]), 32'h2C93);
    check("fast_rd_valid", 32'(rd_valid_v[1]), 32'h1);
    check("fast_rd_falls", 32'(fn[1]), 32'd22);

    repeat (5) @(posedge clk_x);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
